pwm_regbank: RTL
================

PWM_REGBANK -- requirements
Module: pwm_regbank

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter NUM_CH, default 4, SHALL set the number of PWM channels (legal 1..8).
REQ-003 Parameter CNT_W, default 16, SHALL set the counter/compare width (legal 8 or 16).
REQ-004 Parameter ADDR_W, default 8, SHALL set the address width.
REQ-005 Ports:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- read  in  1  read strobe
- write  in  1  write strobe
- addr  in  ADDR_W  byte address
- data_write  in  8  write data
- data_read  out  8  read data
- read_valid  out  1  data_read valid
- counter_val  in  CNT_W  live counter
- update_evt  in  1  counter period boundary pulse
- period  out  CNT_W  active period
- en  out  1  counter enable
- count_reset  out  1  counter reset pulse
- upnotdown  out  1  count direction
- prescale  out  8  prescaler
- pwm_en  out  NUM_CH  per-channel enable
- functions  out  2*NUM_CH  per-channel mode, ch0 in LSBs
- compare1  out  NUM_CH*CNT_W  active compare1, ch0 in LSBs
- compare2  out  NUM_CH*CNT_W  active compare2, ch0 in LSBs

Function
REQ-006 Global map SHALL be:
- 0x00/0x01 PERIOD lo/hi
- 0x02 CTRL: b0 en, b1 upnotdown, b2 count_reset (write-1 pulse, reads 0)
- 0x03 PRESCALE
- 0x04/0x05 COUNTER_VAL lo/hi (read-only)
- 0x06 PWM_EN mask
- 0x07 STATUS: b0 update_pending (read-only)
REQ-007 Channel n SHALL sit at base 0x10+8n: +0/+1 CMP1 lo/hi, +2/+3 CMP2 lo/hi, +4 FUNCTIONS[1:0].
REQ-008 Writes SHALL take effect on the clock edge where write=1; writes to unmapped or read-only addresses, and to hi bytes when CNT_W=8, SHALL be ignored.
REQ-009 Reads SHALL have 1-cycle latency: data_read and read_valid are registered the cycle after read=1; read_valid is high for exactly that cycle; data_read holds its last value otherwise.
REQ-010 Unmapped addresses, hi bytes when CNT_W=8, reserved bits, and channels >= NUM_CH SHALL read 0.
REQ-011 Reading COUNTER_VAL lo SHALL snapshot counter_val[CNT_W-1:8] into a hold register; COUNTER_VAL hi SHALL return that snapshot, giving a coherent 16-bit value.
REQ-012 count_reset SHALL be high for exactly one cycle after a write of CTRL with b2=1.
REQ-013 PERIOD, CMP1, CMP2 and FUNCTIONS SHALL be double-buffered: writes go to staging copies, and outputs show active copies.
REQ-014 Writing any staged register SHALL set update_pending.
REQ-015 While update_pending=1, either update_evt=1 or en=0 SHALL copy all staging to active on that edge and clear update_pending.
REQ-016 When a staged write and an update coincide in the same cycle, the pre-write staging values SHALL transfer to active, the written byte SHALL land in staging, and update_pending SHALL remain 1.
REQ-017 Staged register reads SHALL return the staging copy.
REQ-018 CTRL, PRESCALE and PWM_EN SHALL be unbuffered and take effect immediately.
REQ-019 read and write asserted in the same cycle SHALL both be performed; the read returns the pre-write value.

Reset
REQ-020 When rst=1 at a clock edge, all staging, active, hold and output registers SHALL go to 0, including data_read, read_valid, count_reset and update_pending; rst SHALL take priority over read, write and update_evt.
REQ-021 Reset asserted mid-read SHALL cancel that read, so read_valid=0 on the following cycle.

Configuration
REQ-022 With PWM_REGBANK_SHADOW_EN defined, REQ-013..REQ-016 SHALL apply.
REQ-023 Without PWM_REGBANK_SHADOW_EN, staged registers SHALL be single-copy and update immediately on write, and STATUS.b0 SHALL read 0.

Structure
REQ-024 A shared package pwm_pkg SHALL hold the address constants, CTRL bit indices, channel base/stride (0x10/8) and FUNCTIONS encodings.
REQ-025 One sub-module, pwm_ch_regs, SHALL be instantiated NUM_CH times and hold one channel's staging/active CMP1, CMP2 and FUNCTIONS.

Verification
REQ-026 Write 0x34 to 0x00 and 0x12 to 0x01, en=1, no update_evt: period stays 0 and STATUS reads 0x01; pulse update_evt: period=0x1234 and STATUS reads 0x00.
REQ-027 en=0, write 0x0A to ch2 CMP1 lo (0x20): compare1[2] becomes 0x000A the next cycle.
REQ-028 Write CTRL=0x04: count_reset is high for one cycle, and CTRL then reads 0x00.
REQ-029 counter_val=0xABCD, read 0x04, then change counter_val to 0x0000 and read 0x05: responses are 0xCD then 0xAB, each with read_valid one cycle after read.
REQ-030 Ch0 CMP2 lo write coincides with update_evt (en=1, pending): active takes the old staging value, and STATUS still reads 0x01.
REQ-031 With NUM_CH=4, read 0x30 (ch4): returns 0x00; assert rst while read=1: read_valid stays 0 and all outputs read 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Register-map constants, CTRL bit indices, FUNCTIONS encodings and byte helpers
// shared by the PWM register bank and its per-channel register file.
package pwm_pkg;

  localparam logic [31:0] ADDR_PERIOD_LO = 32'h0000_0000;
  localparam logic [31:0] ADDR_PERIOD_HI = 32'h0000_0001;
  localparam logic [31:0] ADDR_CTRL      = 32'h0000_0002;
  localparam logic [31:0] ADDR_PRESCALE  = 32'h0000_0003;
  localparam logic [31:0] ADDR_CNT_LO    = 32'h0000_0004;
  localparam logic [31:0] ADDR_CNT_HI    = 32'h0000_0005;
  localparam logic [31:0] ADDR_PWM_EN    = 32'h0000_0006;
  localparam logic [31:0] ADDR_STATUS    = 32'h0000_0007;

  localparam int CTRL_EN_BIT     = 32'd0;
  localparam int CTRL_DIR_BIT    = 32'd1;
  localparam int CTRL_CRST_BIT   = 32'd2;
  localparam int STATUS_PEND_BIT = 32'd0;

  localparam logic [31:0] CH_BASE   = 32'h0000_0010;
  localparam logic [31:0] CH_STRIDE = 32'h0000_0008;
  localparam logic [31:0] MAX_CH    = 32'd8;

  localparam logic [2:0] CH_CMP1_LO = 3'd0;
  localparam logic [2:0] CH_CMP1_HI = 3'd1;
  localparam logic [2:0] CH_CMP2_LO = 3'd2;
  localparam logic [2:0] CH_CMP2_HI = 3'd3;
  localparam logic [2:0] CH_FUNC    = 3'd4;

  typedef enum logic [1:0] {
    FUNC_OFF    = 2'b00,
    FUNC_SINGLE = 2'b01,
    FUNC_DUAL   = 2'b10,
    FUNC_INVERT = 2'b11
  } pwm_func_e;

  function automatic logic [15:0] set_byte(input logic [15:0] cur, input logic hi,
                                           input logic [7:0] b);
    logic [15:0] r;
    r = cur;
    if (hi) r[15:8] = b;
    else    r[7:0]  = b;
    return r;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [15:0] v, input logic hi);
    return hi ? v[15:8] : v[7:0];
  endfunction

endpackage

// File: rtl/pwm_ch_regs.sv
// One PWM channel's CMP1/CMP2/FUNCTIONS registers with byte write and readback.
// Double-buffered only when PWM_REGBANK_SHADOW_EN is defined.
module pwm_ch_regs
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [2:0]       reg_sel,
  input  logic [7:0]       wr_data,
  input  logic             update,
  output logic [7:0]       rd_data,
  output logic [CNT_W-1:0] cmp1,
  output logic [CNT_W-1:0] cmp2,
  output logic [1:0]       func
);

  logic [CNT_W-1:0] stage_cmp1_r;
  logic [CNT_W-1:0] stage_cmp2_r;
  pwm_func_e        stage_func_r;

  // Staging copies take byte writes
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_cmp1_r <= '0;
      stage_cmp2_r <= '0;
      stage_func_r <= FUNC_OFF;
    end else if (wr_en) begin
      case (reg_sel)
        CH_CMP1_LO, CH_CMP1_HI:
          stage_cmp1_r <= CNT_W'(set_byte(16'(stage_cmp1_r), reg_sel[0], wr_data));
        CH_CMP2_LO, CH_CMP2_HI:
          stage_cmp2_r <= CNT_W'(set_byte(16'(stage_cmp2_r), reg_sel[0], wr_data));
        CH_FUNC:
          stage_func_r <= pwm_func_e'(wr_data[1:0]);
        default: ;
      endcase
    end
  end

  // Readback always reflects the staging copy
  always_comb begin
    rd_data = 8'h00;
    case (reg_sel)
      CH_CMP1_LO, CH_CMP1_HI: rd_data = byte_sel(16'(stage_cmp1_r), reg_sel[0]);
      CH_CMP2_LO, CH_CMP2_HI: rd_data = byte_sel(16'(stage_cmp2_r), reg_sel[0]);
      CH_FUNC:                rd_data = {6'd0, stage_func_r};
      default:                rd_data = 8'h00;
    endcase
  end

`ifdef PWM_REGBANK_SHADOW_EN
  logic [CNT_W-1:0] act_cmp1_r;
  logic [CNT_W-1:0] act_cmp2_r;
  logic [1:0]       act_func_r;

  // Active copies load from staging on an update
  always_ff @(posedge clk) begin
    if (rst) begin
      act_cmp1_r <= '0;
      act_cmp2_r <= '0;
      act_func_r <= 2'b00;
    end else if (update) begin
      act_cmp1_r <= stage_cmp1_r;
      act_cmp2_r <= stage_cmp2_r;
      act_func_r <= stage_func_r;
    end
  end

  assign cmp1 = act_cmp1_r;
  assign cmp2 = act_cmp2_r;
  assign func = act_func_r;
`else
  logic unused_update_s;
  assign unused_update_s = update;

  assign cmp1 = stage_cmp1_r;
  assign cmp2 = stage_cmp2_r;
  assign func = stage_func_r;
`endif

endmodule

// File: rtl/pwm_regbank.sv
// Byte-addressed register bank for a multi-channel PWM timer.
// Define PWM_REGBANK_SHADOW_EN to double-buffer PERIOD and the channel registers.
module pwm_regbank
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [7:0]              data_write,
  output logic [7:0]              data_read,
  output logic                    read_valid,
  input  logic [CNT_W-1:0]        counter_val,
  input  logic                    update_evt,
  output logic [CNT_W-1:0]        period,
  output logic                    en,
  output logic                    count_reset,
  output logic                    upnotdown,
  output logic [7:0]              prescale,
  output logic [NUM_CH-1:0]       pwm_en,
  output logic [2*NUM_CH-1:0]     functions,
  output logic [NUM_CH*CNT_W-1:0] compare1,
  output logic [NUM_CH*CNT_W-1:0] compare2
);

  localparam bit HAS_HI = (CNT_W == 32'd16);

  logic [31:0]      addr_ext_s;
  logic             ch_hit_s;
  logic             ch_valid_s;
  logic [2:0]       ch_idx_s;
  logic [2:0]       ch_reg_s;
  logic             ch_wr_ok_s;
  logic             ch_wr_s;
  logic             per_wr_s;
  logic             per_hi_s;
  logic             staged_wr_s;
  logic             update_s;
  logic             pending_s;
  logic [7:0]       rd_data_s;
  logic [7:0]       ch_rd_arr_s [8];
  logic [CNT_W-1:0] stage_period_r;
  logic [7:0]       hold_r;

  assign addr_ext_s = 32'(addr);
  assign ch_hit_s   = (addr_ext_s >= CH_BASE) && (addr_ext_s < CH_BASE + CH_STRIDE * MAX_CH);
  assign ch_idx_s   = 3'((addr_ext_s - CH_BASE) >> 32'd3);
  assign ch_reg_s   = addr_ext_s[2:0];
  assign ch_valid_s = ch_hit_s && ({29'd0, ch_idx_s} < 32'(NUM_CH));

  // Hi-byte offsets only exist for 16-bit counters
  always_comb begin
    ch_wr_ok_s = 1'b0;
    case (ch_reg_s)
      CH_CMP1_LO, CH_CMP2_LO, CH_FUNC: ch_wr_ok_s = 1'b1;
      CH_CMP1_HI, CH_CMP2_HI:          ch_wr_ok_s = HAS_HI;
      default:                         ch_wr_ok_s = 1'b0;
    endcase
  end

  assign ch_wr_s     = write && ch_valid_s && ch_wr_ok_s;
  assign per_hi_s    = (addr_ext_s == ADDR_PERIOD_HI);
  assign per_wr_s    = write && ((addr_ext_s == ADDR_PERIOD_LO) || (per_hi_s && HAS_HI));
  assign staged_wr_s = per_wr_s || ch_wr_s;

`ifdef PWM_REGBANK_SHADOW_EN
  logic             pending_r;
  logic [CNT_W-1:0] act_period_r;

  // An update uses pre-write state, so a coinciding write stays pending
  assign update_s  = pending_r && (update_evt || !en);
  assign pending_s = pending_r;

  // Pending flag and active PERIOD copy
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r    <= 1'b0;
      act_period_r <= '0;
    end else begin
      if (staged_wr_s)   pending_r <= 1'b1;
      else if (update_s) pending_r <= 1'b0;
      if (update_s) act_period_r <= stage_period_r;
    end
  end

  assign period = act_period_r;
`else
  logic unused_shadow_s;
  assign unused_shadow_s = update_evt ^ staged_wr_s;
  assign update_s        = 1'b0;
  assign pending_s       = 1'b0;
  assign period          = stage_period_r;
`endif

  // PERIOD staging copy
  always_ff @(posedge clk) begin
    if (rst) stage_period_r <= '0;
    else if (per_wr_s)
      stage_period_r <= CNT_W'(set_byte(16'(stage_period_r), per_hi_s, data_write));
  end

  // Unbuffered control registers and the one-cycle count_reset pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      en          <= 1'b0;
      upnotdown   <= 1'b0;
      count_reset <= 1'b0;
      prescale    <= 8'h00;
      pwm_en      <= '0;
    end else begin
      count_reset <= write && (addr_ext_s == ADDR_CTRL) && data_write[CTRL_CRST_BIT];
      if (write && (addr_ext_s == ADDR_CTRL)) begin
        en        <= data_write[CTRL_EN_BIT];
        upnotdown <= data_write[CTRL_DIR_BIT];
      end
      if (write && (addr_ext_s == ADDR_PRESCALE)) prescale <= data_write;
      if (write && (addr_ext_s == ADDR_PWM_EN))   pwm_en   <= data_write[NUM_CH-1:0];
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_ch
    if (g < NUM_CH) begin : g_inst
      pwm_ch_regs #(.CNT_W(CNT_W)) u_ch (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ch_wr_s && (ch_idx_s == 3'(g))),
        .reg_sel (ch_reg_s),
        .wr_data (data_write),
        .update  (update_s),
        .rd_data (ch_rd_arr_s[g]),
        .cmp1    (compare1[g*CNT_W +: CNT_W]),
        .cmp2    (compare2[g*CNT_W +: CNT_W]),
        .func    (functions[2*g +: 2])
      );
    end else begin : g_none
      assign ch_rd_arr_s[g] = 8'h00;
    end
  end

  // Read multiplexer; unmapped and reserved bits read as zero
  always_comb begin
    rd_data_s = 8'h00;
    case (addr_ext_s)
      ADDR_PERIOD_LO: rd_data_s = byte_sel(16'(stage_period_r), 1'b0);
      ADDR_PERIOD_HI: rd_data_s = byte_sel(16'(stage_period_r), 1'b1);
      ADDR_CTRL: begin
        rd_data_s[CTRL_EN_BIT]  = en;
        rd_data_s[CTRL_DIR_BIT] = upnotdown;
      end
      ADDR_PRESCALE:  rd_data_s = prescale;
      ADDR_CNT_LO:    rd_data_s = byte_sel(16'(counter_val), 1'b0);
      ADDR_CNT_HI:    rd_data_s = hold_r;
      ADDR_PWM_EN:    rd_data_s = 8'(pwm_en);
      ADDR_STATUS:    rd_data_s[STATUS_PEND_BIT] = pending_s;
      default:        rd_data_s = ch_valid_s ? ch_rd_arr_s[ch_idx_s] : 8'h00;
    endcase
  end

  // Registered read response; a COUNTER_VAL lo read snapshots the upper byte
  always_ff @(posedge clk) begin
    if (rst) begin
      data_read  <= 8'h00;
      read_valid <= 1'b0;
      hold_r     <= 8'h00;
    end else begin
      read_valid <= read;
      if (read) begin
        data_read <= rd_data_s;
        if (addr_ext_s == ADDR_CNT_LO) hold_r <= byte_sel(16'(counter_val), 1'b1);
      end
    end
  end

endmodule
